hex_scan_display: RTL and testbench
===================================

Name: hex_scan_display

Overview:
Parametrised N-digit multiplexed hexadecimal seven-segment display driver. It holds a display word and time-multiplexes one digit at a time onto a shared segment bus with per-digit anode enables. It adds frame-synchronous (tear-free) value updates, per-digit blanking, leading-zero suppression and inter-digit dead time. It sits between the datapath (value producer) and board display pins.

Parameters:
NUM_DIGITS, 4, number of hex digits / anode lines (1..8)
REFRESH_DIV, 50000, clocks per digit slot (>= 2)
ACTIVE_LOW, 1, 1: seg/dp/an driven active-low; 0: active-high

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  1-cycle strobe: capture value/dp_in into shadow
value  in  4*NUM_DIGITS  hex word; nibble k is digit k (digit 0 = least significant)
dp_in  in  NUM_DIGITS  decimal-point request per digit
blank_mask  in  NUM_DIGITS  1 = digit k always dark (sampled live)
lz_suppress  in  1  1 = blank leading zero digits (sampled live)
seg  out  7  segments, seg[0]=a .. seg[6]=g
dp  out  1  decimal point
an  out  NUM_DIGITS  digit enables, one-hot when active
pending  out  1  shadow holds value not yet displayed
frame_tick  out  1  1-cycle pulse at each frame start (digit index wraps to 0)

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on reset. All state and all outputs are registered.
- Reset values:
  - display, shadow and dp registers = 0; pending = 0; frame_tick = 0.
  - digit index = 0; prescaler = 0.
  - an = all inactive; seg = all off; dp = off. "Off/inactive" is 1 when ACTIVE_LOW=1, else 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. At the terminal count the digit index increments, wrapping NUM_DIGITS-1 -> 0.
- Commit: on the terminal count where the index wraps to 0:
  - frame_tick pulses on the following cycle.
  - If pending, the display register takes the shadow and pending clears.
- Load:
  - load=1 writes value/dp_in into the shadow and sets pending next cycle.
  - Repeated loads before commit: last one wins.
  - load on the commit cycle: the display takes the incoming value directly; pending ends 0.
- Dead time: during prescaler count 0 of every slot, an is all inactive (anti-ghosting).
  - Otherwise an drives only the current index active, unless that digit is dark.
- A digit is dark if either:
  - its blank_mask bit is set, or
  - lz_suppress=1, its nibble is 0, and all higher nibbles are 0. Digit 0 is never leading-zero suppressed.
- A dark digit keeps its anode inactive, seg all off and dp off.
- Output latency: seg/dp/an reflect index and prescaler state with exactly 1 cycle of register delay.
- Glyphs, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Bits are inverted when ACTIVE_LOW=1.
- Reset mid-frame: the state returns to reset values on the next edge. Any pending shadow is discarded.

Decomposition:
- Package hex_disp_pkg holds:
  - the 16-entry glyph constant array;
  - SEG_OFF;
  - function hex_to_seg(nibble).
- Sub-module hex_seg_rom: combinational 4->7 glyph lookup, instantiated once on the muxed nibble.
- Prescaler, index, shadow/commit logic and output registers stay in the top level.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
- Reset, then idle -> after reset: an=4'hF, seg=7'h7F for 1 cycle. Then each slot gives 1 dead cycle (an=F) plus 3 cycles with an=E,D,B,7 in turn. seg=7'h40 (glyph 0) for digit 0.
- load value=16'h12AF mid-frame -> pending=1, display unchanged until frame_tick. Next frame shows digit0 seg=~71=0E, digit1 ~77=08, digit2 ~5B=24, digit3 ~06=79. pending=0.
- Two loads before commit (16'h1111 then 16'h2222) -> only 2222 is displayed. Load coincident with commit cycle -> that value is shown in the same frame and pending stays 0.
- lz_suppress=1, value=16'h0030 -> digits 3,2 dark (an bits held 1, seg=7F). Digit1 shows 3, digit0 shows 0. value=0 -> only digit 0 lit.
- blank_mask=4'b0101, dp_in=4'b0010 -> digits 0,2 never enabled. dp=0 only during digit 1's active cycles.
- Assert reset for 1 cycle mid-slot with pending=1 -> next cycle all outputs off, pending=0, index 0. Previously loaded shadow is never displayed.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the multiplexed hex seven-segment driver.
// Provides the active-high gfedcba glyph table, the "all segments off"
// code (active-high) and a lookup helper used by hex_seg_rom.
package hex_disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/hex_seg_rom.sv
// Combinational 4-bit hex to seven-segment glyph lookup (active-high).
// Ports:
//   nibble_i : hex digit to render
//   seg_o    : segments gfedcba, seg_o[0] = a
module hex_seg_rom
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/hex_scan_display.sv
// N-digit time-multiplexed hex seven-segment display driver.
// Holds a display word, scans one digit per slot onto a shared segment bus,
// with tear-free frame-synchronous updates, per-digit blanking, leading-zero
// suppression and one dead cycle at the start of each slot.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   load, value, dp_in : 1-cycle strobe capturing the next word / dp requests
//   blank_mask         : live per-digit force-dark
//   lz_suppress        : live leading-zero suppression enable
//   seg, dp, an        : registered display pins (polarity per ACTIVE_LOW)
//   pending            : a loaded word is waiting for the next frame start
//   frame_tick         : 1-cycle pulse when the digit index wraps to 0
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit          AL = (ACTIVE_LOW != 0);

  logic [CW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   dpr_q, dpr_d, dpsh_q, dpsh_d;
  logic                    pending_q, pending_d;
  logic                    tick_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  logic                    terminal, wrap, dead, lz_dark, dark, lit;
  logic [3:0]              cur_nib;
  logic [6:0]              rom_seg, seg_hi;
  logic [4*NUM_DIGITS-1:0] upper;
  logic [NUM_DIGITS-1:0]   an_hi;
  logic                    dp_hi;

  assign terminal = (presc_q == CW'(REFRESH_DIV - 1));
  assign wrap     = terminal && (idx_q == IW'(NUM_DIGITS - 1));

  // Prescaler, digit index and shadow/commit next-state.
  always_comb begin
    presc_d   = terminal ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    disp_d    = disp_q;
    dpr_d     = dpr_q;
    shadow_d  = shadow_q;
    dpsh_d    = dpsh_q;
    pending_d = pending_q;
    if (terminal) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    if (wrap) begin
      // A load landing on the commit edge bypasses the shadow so it is
      // visible in the frame that starts now.
      if (load) begin
        disp_d    = value;
        dpr_d     = dp_in;
        shadow_d  = value;
        dpsh_d    = dp_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        dpr_d     = dpsh_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = value;
      dpsh_d    = dp_in;
      pending_d = 1'b1;
    end
  end

  assign cur_nib = disp_q[4*idx_q +: 4];

  hex_seg_rom u_rom (
    .nibble_i (cur_nib),
    .seg_o    (rom_seg)
  );

  // Leading zero: this nibble and every higher one are zero.
  assign upper   = disp_q >> {idx_q, 2'b00};
  assign lz_dark = lz_suppress && (idx_q != '0) && (upper == '0);
  assign dark    = blank_mask[idx_q] || lz_dark;
  assign dead    = (presc_q == '0);
  assign lit     = !dead && !dark;

  always_comb begin
    an_hi  = '0;
    seg_hi = SEG_OFF;
    dp_hi  = 1'b0;
    if (lit) begin
      an_hi  = NUM_DIGITS'(1) << idx_q;
      seg_hi = rom_seg;
      dp_hi  = dpr_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      dpr_q     <= '0;
      shadow_q  <= '0;
      dpsh_q    <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= AL ? '1 : '0;
      seg_q     <= AL ? ~SEG_OFF : SEG_OFF;
      dp_q      <= AL;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      dpr_q     <= dpr_d;
      shadow_q  <= shadow_d;
      dpsh_q    <= dpsh_d;
      pending_q <= pending_d;
      tick_q    <= wrap;
      an_q      <= AL ? ~an_hi : an_hi;
      seg_q     <= AL ? ~seg_hi : seg_hi;
      dp_q      <= AL ? ~dp_hi : dp_hi;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_scan_display.sv
module tb_hex_scan_display;

  typedef struct packed {
    logic [3:0]  lit;   // digits expected to light in their active cycles
    logic [27:0] segs;  // active-low glyph per digit, digit k at [7k +: 7]
    logic [3:0]  dpon;  // digits whose dp is expected on
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_suppress = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  frame_t exp_q [$];

  hex_scan_display #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .pending     (pending),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Returns at posedge+1 of the first cycle showing frame_tick high.
  task automatic wait_frame();
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!frame_tick && k < 40);
    if (!frame_tick) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_timeout: got no frame_tick in %0d cycles expected one", k);
    end
  endtask

  task automatic push_frame(input logic [3:0] lit, input logic [27:0] segs, input logic [3:0] dpon);
    frame_t f;
    f.lit  = lit;
    f.segs = segs;
    f.dpon = dpon;
    exp_q.push_back(f);
  endtask

  task automatic mid_load(input int gap, input logic [15:0] v, input logic [3:0] d);
    repeat (gap) @(posedge clk);
    #1;
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  // Monitor: each frame_tick opens a frame; with an expectation queued, the
  // next 16 cycles (4 slots x 4 prescaler counts) are compared as one test.
  initial begin
    frame_t cur;
    bit in_frame = 0;
    bit ferr = 0;
    int j = 0;
    int slot, c;
    logic [3:0] onehot, ea;
    logic [6:0] es;
    logic ed;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 0;
      end else begin
        if (in_frame) begin
          slot = j / 4;
          c    = j % 4;
          if (c == 0 || !cur.lit[slot]) begin
            ea = 4'hF; es = 7'h7F; ed = 1'b1;
          end else begin
            onehot = 4'b0001 << slot;
            ea = ~onehot;
            es = cur.segs[7*slot +: 7];
            ed = ~cur.dpon[slot];
          end
          if (!ferr && (an !== ea || seg !== es || dp !== ed)) begin
            ferr = 1;
            $display("FAIL frame_cycle%0d: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     j, an, seg, dp, ea, es, ed);
          end
          j++;
          if (j == 16) begin
            n_tests++;
            if (ferr) n_fail++;
            in_frame = 0;
          end
        end
        if (frame_tick && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          in_frame = 1;
          ferr = 0;
          j = 0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    check("reset_pending", 32'(pending), 32'h0);
    check("reset_tick", 32'(frame_tick), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("first_dead_an", 32'(an), 32'hF);
    @(posedge clk); #1;
    check("first_digit0_an", 32'(an), 32'hE);
    check("first_digit0_seg", 32'(seg), 32'h40);

    // Idle zeros frame, then a mid-frame load that must wait for the commit.
    wait_frame();
    push_frame(4'hF, {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0);
    mid_load(4, 16'h12AF, 4'h0);
    check("pending_after_load", 32'(pending), 32'h1);

    wait_frame();
    check("pending_after_commit", 32'(pending), 32'h0);
    push_frame(4'hF, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0);
    mid_load(3, 16'h1111, 4'h0);
    mid_load(3, 16'h2222, 4'h0);
    check("pending_two_loads", 32'(pending), 32'h1);

    // Last load wins; then a load placed exactly on the commit edge.
    wait_frame();
    push_frame(4'hF, {7'h24, 7'h24, 7'h24, 7'h24}, 4'h0);
    repeat (15) @(posedge clk);
    #1;
    check("pending_before_commit_load", 32'(pending), 32'h0);
    value = 16'h3C5D;
    load  = 1'b1;
    wait_frame();
    load  = 1'b0;
    check("pending_commit_load", 32'(pending), 32'h0);
    push_frame(4'hF, {7'h30, 7'h46, 7'h12, 7'h21}, 4'h0);
    mid_load(4, 16'h0030, 4'h0);

    // Leading-zero suppression.
    wait_frame();
    lz_suppress = 1'b1;
    push_frame(4'b0011, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'h0);
    mid_load(4, 16'h0000, 4'h0);

    wait_frame();
    push_frame(4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h0);
    mid_load(4, 16'h8888, 4'b0011);

    // Blanking: dp request on dark digit 0 must stay off.
    wait_frame();
    lz_suppress = 1'b0;
    blank_mask  = 4'b0101;
    push_frame(4'b1010, {7'h00, 7'h7F, 7'h00, 7'h7F}, 4'b0010);

    // Reset mid-slot with a pending shadow.
    wait_frame();
    mid_load(4, 16'h5555, 4'hF);
    check("pending_before_reset", 32'(pending), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_an", 32'(an), 32'hF);
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_dp", 32'(dp), 32'h1);
    check("midreset_pending", 32'(pending), 32'h0);
    reset = 1'b0;
    blank_mask = 4'h0;

    wait_frame();
    push_frame(4'hF, {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0);
    repeat (18) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
